// File: rtl/cnn_pkg.sv
// Shared CNN helpers: default element width, packed-bus index helper and the
// signed/unsigned element compare used by pooling and FC stages.
package cnn_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int CMP_MAX_W      = 64;

   function automatic int elem_lo(input int c, input int x, input int cols, input int w);
      return (c * cols + x) * w;
   endfunction

   // Flipping the sign bit maps two's complement order onto unsigned order.
   function automatic logic elem_gt(input logic [CMP_MAX_W-1:0] a,
                                    input logic [CMP_MAX_W-1:0] b,
                                    input int                   w,
                                    input logic                 sgn);
      logic [CMP_MAX_W-1:0] bias;
      bias = sgn ? (CMP_MAX_W'(1) << (w - 1)) : '0;
      return (a ^ bias) > (b ^ bias);
   endfunction

endpackage

// File: rtl/pool2x2_stream_max4_cmp.sv
// max4_cmp: combinational maximum of four elements, signed or unsigned.
module max4_cmp
   import cnn_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int SIGNED = 1
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] y
);

   localparam logic IS_SIGNED = (SIGNED != 0);

   logic [DATA_W-1:0] m_ab;
   logic [DATA_W-1:0] m_cd;

   always_comb begin
      m_ab = elem_gt(CMP_MAX_W'(a), CMP_MAX_W'(b), DATA_W, IS_SIGNED) ? a : b;
      m_cd = elem_gt(CMP_MAX_W'(c), CMP_MAX_W'(d), DATA_W, IS_SIGNED) ? c : d;
      y    = elem_gt(CMP_MAX_W'(m_ab), CMP_MAX_W'(m_cd), DATA_W, IS_SIGNED) ? m_ab : m_cd;
   end

endmodule

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: 2x2/stride-2 max pool over full rows of CH channels.
// Optional ReLU on pooled elements when POOL_RELU_EN is defined.
module pool2x2_stream
   import cnn_pkg::*;
#(
   parameter int CH     = 4,
   parameter int COLS   = 24,
   parameter int ROWS   = 24,
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int SIGNED = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             valid_in,
   input  logic [CH*COLS*DATA_W-1:0]        data_in,
   output logic [CH*(COLS/2)*DATA_W-1:0]    data_out,
   output logic                             valid_out,
   output logic                             pool_end
);

   localparam int OUT_COLS = COLS / 2;
   localparam int IN_W     = CH * COLS * DATA_W;
   localparam int OUT_W    = CH * OUT_COLS * DATA_W;
   localparam int CNT_W    = (ROWS > 2) ? $clog2(ROWS) : 1;

   generate
      if ((COLS % 2) != 0 || (ROWS % 2) != 0 || COLS < 2 || ROWS < 2 ||
          CH < 1 || DATA_W < 1 || DATA_W > CMP_MAX_W) begin : g_bad_cfg
         $fatal(1, "pool2x2_stream: COLS/ROWS must be even and >=2, CH/DATA_W >= 1");
      end
   endgenerate

   logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic [IN_W-1:0]  row_buf_q, row_buf_d;
   logic [OUT_W-1:0] data_out_q, data_out_d;
   logic             valid_out_q, valid_out_d;
   logic             pool_end_q, pool_end_d;
   logic [OUT_W-1:0] pooled;
   logic [OUT_W-1:0] pooled_post;
   logic             accept;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      for (genvar j = 0; j < OUT_COLS; j++) begin : g_col
         max4_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_max (
            .a(row_buf_q[elem_lo(c, 2*j,     COLS, DATA_W) +: DATA_W]),
            .b(row_buf_q[elem_lo(c, 2*j + 1, COLS, DATA_W) +: DATA_W]),
            .c(data_in  [elem_lo(c, 2*j,     COLS, DATA_W) +: DATA_W]),
            .d(data_in  [elem_lo(c, 2*j + 1, COLS, DATA_W) +: DATA_W]),
            .y(pooled   [elem_lo(c, j, OUT_COLS, DATA_W) +: DATA_W])
         );
      end
   end

`ifdef POOL_RELU_EN
   function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
      return ((SIGNED != 0) && v[DATA_W-1]) ? '0 : v;
   endfunction
`endif

   always_comb begin
      pooled_post = pooled;
`ifdef POOL_RELU_EN
      for (int k = 0; k < CH * OUT_COLS; k++) begin
         pooled_post[k*DATA_W +: DATA_W] = relu(pooled[k*DATA_W +: DATA_W]);
      end
`endif
   end

   // Even rows park in row_buf; odd rows complete a 2x2 window with it.
   always_comb begin
      accept      = valid_in & en;
      row_cnt_d   = row_cnt_q;
      row_buf_d   = row_buf_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      pool_end_d  = 1'b0;
      if (accept) begin
         row_cnt_d = (row_cnt_q == CNT_W'(ROWS - 1)) ? '0 : row_cnt_q + 1'b1;
         if (!row_cnt_q[0]) begin
            row_buf_d = data_in;
         end else begin
            data_out_d  = pooled_post;
            valid_out_d = 1'b1;
            pool_end_d  = (row_cnt_q == CNT_W'(ROWS - 1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_q   <= '0;
         row_buf_q   <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         pool_end_q  <= 1'b0;
      end else begin
         row_cnt_q   <= row_cnt_d;
         row_buf_q   <= row_buf_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         pool_end_q  <= pool_end_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign pool_end  = pool_end_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: a small unsigned instance driven from a vector
// table, and a default signed instance driven by frames against a scoreboard.
module tb_pool2x2_stream;

   localparam int B_CH   = 4;
   localparam int B_COLS = 24;
   localparam int B_ROWS = 24;
   localparam int B_OC   = B_COLS / 2;
   localparam int B_IN   = B_CH * B_COLS * 8;
   localparam int B_OUT  = B_CH * B_OC * 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_a, en_a, vin_a;
   logic [31:0] din_a;
   logic [15:0] dout_a;
   logic        vout_a, pend_a;

   logic             rst_b, en_b, vin_b;
   logic [B_IN-1:0]  din_b;
   logic [B_OUT-1:0] dout_b;
   logic             vout_b, pend_b;

   pool2x2_stream #(.CH(1), .COLS(4), .ROWS(2), .DATA_W(8), .SIGNED(0)) u_dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .valid_in(vin_a), .data_in(din_a),
      .data_out(dout_a), .valid_out(vout_a), .pool_end(pend_a)
   );

   pool2x2_stream #(.CH(B_CH), .COLS(B_COLS), .ROWS(B_ROWS), .DATA_W(8), .SIGNED(1)) u_dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .valid_in(vin_b), .data_in(din_b),
      .data_out(dout_b), .valid_out(vout_b), .pool_end(pend_b)
   );

   task automatic chk(input string name, input logic [B_OUT-1:0] act, input logic [B_OUT-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [B_OUT-1:0] pool_model(input logic [B_IN-1:0] r0, input logic [B_IN-1:0] r1);
      logic [B_OUT-1:0] res;
      logic signed [7:0] v [4];
      logic signed [7:0] m;
      res = '0;
      for (int c = 0; c < B_CH; c++) begin
         for (int j = 0; j < B_OC; j++) begin
            v[0] = r0[(c*B_COLS + 2*j) * 8 +: 8];
            v[1] = r0[(c*B_COLS + 2*j + 1) * 8 +: 8];
            v[2] = r1[(c*B_COLS + 2*j) * 8 +: 8];
            v[3] = r1[(c*B_COLS + 2*j + 1) * 8 +: 8];
            m = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
`ifdef POOL_RELU_EN
            if (m < 0) m = 0;
`endif
            res[(c*B_OC + j) * 8 +: 8] = m;
         end
      end
      return res;
   endfunction

   function automatic logic [B_IN-1:0] hash_row(input int seed, input int r);
      logic [B_IN-1:0] res;
      for (int c = 0; c < B_CH; c++)
         for (int x = 0; x < B_COLS; x++)
            res[(c*B_COLS + x) * 8 +: 8] = 8'((c*37 + x*11 + r*53 + seed*97) ^ (x*r));
      return res;
   endfunction

   // Scoreboard for instance B
   typedef struct { logic [B_OUT-1:0] data; logic last; } exp_t;
   exp_t             exp_q[$];
   exp_t             e_mon;
   int               tb_cnt = 0;
   logic [B_IN-1:0]  tb_buf;
   bit               mon_on = 0;
   bit               spacing_on = 0;
   int               pulses = 0;
   int               pend_cnt = 0;
   int               last_pulse = -1;

   task automatic send_b(input logic [B_IN-1:0] row);
      vin_b = 1'b1;
      en_b  = 1'b1;
      din_b = row;
      @(posedge clk);
      if (tb_cnt % 2 == 0) tb_buf = row;
      else exp_q.push_back('{pool_model(tb_buf, row), (tb_cnt == B_ROWS - 1)});
      tb_cnt = (tb_cnt == B_ROWS - 1) ? 0 : tb_cnt + 1;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (pend_b && !vout_b) begin
            checks++;
            failures++;
            $display("FAIL pool_end_without_valid: got pool_end=1 expected 0");
         end
         if (vout_b) begin
            pulses++;
            if (pend_b) pend_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid_out: got 1 expected 0 at cycle %0d", cyc);
            end else begin
               e_mon = exp_q.pop_front();
               chk("pooled_row", dout_b, e_mon.data);
               chk_int("pool_end_flag", int'(pend_b), int'(e_mon.last));
            end
            if (spacing_on && last_pulse >= 0) chk_int("pulse_gap", cyc - last_pulse, 2);
            last_pulse = cyc;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   typedef struct { logic [31:0] r0; logic [31:0] r1; logic [15:0] exp; } vec_a_t;
   vec_a_t va [4];

   initial begin
      logic [B_IN-1:0]  r;
      logic [B_OUT-1:0] ch_exp;
      int p0, pe0;

      va[0] = '{32'h02030501, 32'h09070004, 16'h0905};
      va[1] = '{32'h000001C8, 32'h80FF0403, 16'hFFC8};
      va[2] = '{32'h07070707, 32'h07070707, 16'h0707};
      va[3] = '{32'h00000000, 32'h01000000, 16'h0100};

      rst_a = 1'b1; en_a = 1'b0; vin_a = 1'b0; din_a = '0;
      rst_b = 1'b1; en_b = 1'b0; vin_b = 1'b0; din_b = '0;

      // Instance A: reset state then table vectors
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("a_reset_data", B_OUT'(dout_a), '0);
      chk_int("a_reset_valid", int'(vout_a), 0);
      chk_int("a_reset_pool_end", int'(pend_a), 0);
      rst_a = 1'b0;

      for (int i = 0; i < 4; i++) begin
         vin_a = 1'b1; en_a = 1'b1; din_a = va[i].r0;
         @(posedge clk); @(negedge clk);
         chk_int("a_even_no_valid", int'(vout_a), 0);
         din_a = va[i].r1;
         @(posedge clk); @(negedge clk);
         chk_int("a_odd_valid", int'(vout_a), 1);
         chk("a_pooled", B_OUT'(dout_a), B_OUT'(va[i].exp));
         chk_int("a_pool_end", int'(pend_a), 1);
      end
      vin_a = 1'b0;
      @(posedge clk); @(negedge clk);
      chk_int("a_idle_valid", int'(vout_a), 0);
      chk("a_data_hold", B_OUT'(dout_a), B_OUT'(va[3].exp));

      // Instance B: reset state
      chk("b_reset_data", dout_b, '0);
      chk_int("b_reset_valid", int'(vout_b), 0);
      chk_int("b_reset_pool_end", int'(pend_b), 0);
      rst_b = 1'b0;
      mon_on = 1'b1;

      // Frames 1 and 2 back-to-back
      spacing_on = 1'b1; last_pulse = -1;
      p0 = pulses; pe0 = pend_cnt;
      r = hash_row(1, 0); r[7:0] = 8'hFD; r[15:8] = 8'hF8; send_b(r);
      r = hash_row(1, 1); r[7:0] = 8'hFF; r[15:8] = 8'h80; send_b(r);
      chk_int("signed_valid", int'(vout_b), 1);
`ifdef POOL_RELU_EN
      chk("signed_max_el0", B_OUT'(dout_b[7:0]), B_OUT'(8'h00));
`else
      chk("signed_max_el0", B_OUT'(dout_b[7:0]), B_OUT'(8'hFF));
`endif
      for (int c = 0; c < B_CH; c++)
         for (int x = 0; x < B_COLS; x++)
            r[(c*B_COLS + x) * 8 +: 8] = 8'(c*16 + x);
      for (int c = 0; c < B_CH; c++)
         for (int j = 0; j < B_OC; j++)
            ch_exp[(c*B_OC + j) * 8 +: 8] = 8'(c*16 + 2*j + 1);
      send_b(r);
      send_b(r);
      chk("channel_pattern", dout_b, ch_exp);
      for (int i = 4; i < B_ROWS; i++) send_b(hash_row(1, i));
      send_b(hash_row(2, 0));
      chk_int("frame1_pulses", pulses - p0, 12);
      chk_int("frame1_pool_ends", pend_cnt - pe0, 1);
      for (int i = 1; i < B_ROWS; i++) send_b(hash_row(2, i));
      vin_b = 1'b0;
      @(negedge clk);
      chk_int("frame12_pulses", pulses - p0, 24);
      chk_int("frame12_pool_ends", pend_cnt - pe0, 2);
      spacing_on = 1'b0;

      // Frame 3: enable gap between rows 6 and 7
      p0 = pulses; pe0 = pend_cnt;
      for (int i = 0; i < 7; i++) send_b(hash_row(3, i));
      en_b = 1'b0; vin_b = 1'b1; din_b = hash_row(9, 99);
      repeat (5) @(negedge clk);
      chk_int("en_gap_no_valid", int'(vout_b), 0);
      send_b(hash_row(3, 7));
      chk_int("after_gap_valid", int'(vout_b), 1);
      for (int i = 8; i < B_ROWS; i++) send_b(hash_row(3, i));
      vin_b = 1'b0;
      @(negedge clk);
      chk_int("frame3_pulses", pulses - p0, 12);
      chk_int("frame3_pool_ends", pend_cnt - pe0, 1);

      // Frame 4 aborted by reset after row 9, then frame 5
      p0 = pulses;
      for (int i = 0; i < 10; i++) send_b(hash_row(4, i));
      rst_b = 1'b1; vin_b = 1'b1; en_b = 1'b1; din_b = hash_row(8, 1);
      @(negedge clk);
      chk_int("frame4_pulses", pulses - p0, 5);
      chk_int("queue_drained", exp_q.size(), 0);
      chk("rst_data", dout_b, '0);
      chk_int("rst_valid", int'(vout_b), 0);
      @(negedge clk);
      chk("rst_data_2", dout_b, '0);
      chk_int("rst_pool_end", int'(pend_b), 0);
      rst_b = 1'b0; vin_b = 1'b0;
      exp_q.delete();
      tb_cnt = 0;
      @(negedge clk);
      chk("post_rst_data", dout_b, '0);
      chk_int("post_rst_valid", int'(vout_b), 0);
      p0 = pulses; pe0 = pend_cnt;
      for (int i = 0; i < B_ROWS; i++) send_b(hash_row(5, i));
      vin_b = 1'b0;
      @(negedge clk);
      chk_int("frame5_pulses", pulses - p0, 12);
      chk_int("frame5_pool_ends", pend_cnt - pe0, 1);
      chk_int("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
